pixel_frame_scheduler: RTL and testbench

Raster-order controller sitting between the pixel colour source (fractal/shader core) and the video stream output. Walks the x/y coordinates of a frame, requests one colour per coordinate from the source, and presents each pixel on a valid/ready stream with frame and line markers (`first`, `last_x`, `last_y`). Inserts a programmable inter-frame gap and counts completed frames.

---
 rtl/pixel_pkg.sv | 20 ++
 rtl/raster_counter.sv | 60 ++++++
 rtl/pixel_frame_scheduler.sv | 159 +++++++++++++++
 tb/tb_pixel_frame_scheduler.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_pkg.sv
// Shared types and default constants for the pixel frame scheduler.
package pixel_pkg;

  localparam int DEF_DATA_WIDTH    = 32;
  localparam int DEF_RGB_SIZE      = 24;
  localparam int DEF_SCREEN_WIDTH  = 640;
  localparam int DEF_SCREEN_HEIGHT = 480;
  localparam int DEF_GAP_CYCLES    = 16;

  typedef logic [DEF_RGB_SIZE-1:0] rgb_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_SEND,
    ST_GAP
  } sched_state_t;

endpackage

// File: rtl/raster_counter.sv
// Raster x/y position counter with frame and line markers for the current position.
module raster_counter
  import pixel_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = DEF_SCREEN_HEIGHT
) (
  input  logic                  clk,
  input  logic                  rst_ni,
  input  logic                  advance_i,
  input  logic                  clear_i,
  output logic [DATA_WIDTH-1:0] x_o,
  output logic [DATA_WIDTH-1:0] y_o,
  output logic                  first_o,
  output logic                  last_x_o,
  output logic                  last_y_o
);

  localparam logic [DATA_WIDTH-1:0] XMAX = DATA_WIDTH'(SCREEN_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] YMAX = DATA_WIDTH'(SCREEN_HEIGHT - 1);

  logic [DATA_WIDTH-1:0] x_q, x_d;
  logic [DATA_WIDTH-1:0] y_q, y_d;

  // Next position: clear wins, otherwise step x and wrap into the next line.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clear_i) begin
      x_d = '0;
      y_d = '0;
    end else if (advance_i) begin
      if (x_q == XMAX) begin
        x_d = '0;
        y_d = (y_q == YMAX) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  // Position registers.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o      = x_q;
  assign y_o      = y_q;
  assign first_o  = (x_q == '0) && (y_q == '0);
  assign last_x_o = (x_q == XMAX);
  assign last_y_o = (x_q == XMAX) && (y_q == YMAX);

endmodule

// File: rtl/pixel_frame_scheduler.sv
// Raster-order pixel scheduler: requests colours from a source per coordinate and
// streams them out with frame/line markers, inserting an inter-frame gap.
module pixel_frame_scheduler
  import pixel_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int RBG_SIZE      = DEF_RGB_SIZE,
  parameter int SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
  parameter int GAP_CYCLES    = DEF_GAP_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  output logic                  src_req,
  output logic [DATA_WIDTH-1:0] src_x,
  output logic [DATA_WIDTH-1:0] src_y,
  input  logic [RBG_SIZE-1:0]   src_colour,
  input  logic                  src_valid,
  output logic [RBG_SIZE-1:0]   colour_o,
  output logic [DATA_WIDTH-1:0] next_xpixel,
  output logic [DATA_WIDTH-1:0] next_ypixel,
  output logic                  first,
  output logic                  last_x,
  output logic                  last_y,
  output logic                  valid,
  input  logic                  ready,
  output logic                  busy,
  output logic                  frame_done,
  output logic [15:0]           frame_count
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [GW-1:0] GAP_PEN  = GW'(GAP_CYCLES - 2);

  sched_state_t          state_q;
  logic [GW-1:0]         gap_cnt_q;
  logic [RBG_SIZE-1:0]   colour_q;
  logic [DATA_WIDTH-1:0] xpix_q;
  logic [DATA_WIDTH-1:0] ypix_q;
  logic                  first_q;
  logic                  last_x_q;
  logic                  last_y_q;
  logic                  valid_q;
  logic                  frame_done_q;
  logic [15:0]           frame_count_q;

  logic [DATA_WIDTH-1:0] cnt_x, cnt_y;
  logic                  cnt_first, cnt_last_x, cnt_last_y;
  logic                  handshake;
  logic                  advance;
  logic                  clear;

  // The raster position only moves on a stream handshake; the final pixel of a
  // frame clears it so the next frame restarts at (0,0).
  assign handshake = (state_q == ST_SEND) && ready;
  assign advance   = handshake && !cnt_last_y;
  assign clear     = handshake && cnt_last_y;

  raster_counter #(
    .DATA_WIDTH   (DATA_WIDTH),
    .SCREEN_WIDTH (SCREEN_WIDTH),
    .SCREEN_HEIGHT(SCREEN_HEIGHT)
  ) u_raster (
    .clk      (clk),
    .rst_ni   (reset_n),
    .advance_i(advance),
    .clear_i  (clear),
    .x_o      (cnt_x),
    .y_o      (cnt_y),
    .first_o  (cnt_first),
    .last_x_o (cnt_last_x),
    .last_y_o (cnt_last_y)
  );

  // Scheduler FSM with stream capture registers, gap timer and frame counter.
  // frame_done is raised on the edge entering the final gap cycle so the pulse
  // coincides with that cycle rather than trailing it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      gap_cnt_q     <= '0;
      colour_q      <= '0;
      xpix_q        <= '0;
      ypix_q        <= '0;
      first_q       <= 1'b0;
      last_x_q      <= 1'b0;
      last_y_q      <= 1'b0;
      valid_q       <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (en) state_q <= ST_REQ;
        end
        ST_REQ: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (src_valid) begin
            colour_q <= src_colour;
            xpix_q   <= cnt_x;
            ypix_q   <= cnt_y;
            first_q  <= cnt_first;
            last_x_q <= cnt_last_x;
            last_y_q <= cnt_last_y;
            valid_q  <= 1'b1;
            state_q  <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (ready) begin
            valid_q <= 1'b0;
            if (cnt_last_y) begin
              state_q   <= ST_GAP;
              gap_cnt_q <= '0;
              if (GAP_CYCLES == 1) begin
                frame_done_q  <= 1'b1;
                frame_count_q <= frame_count_q + 16'd1;
              end
            end else begin
              state_q <= en ? ST_REQ : ST_IDLE;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            frame_done_q <= 1'b0;
            state_q      <= en ? ST_REQ : ST_IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
            if (gap_cnt_q == GAP_PEN) begin
              frame_done_q  <= 1'b1;
              frame_count_q <= frame_count_q + 16'd1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign src_req     = (state_q == ST_REQ);
  assign busy        = (state_q != ST_IDLE);
  assign src_x       = cnt_x;
  assign src_y       = cnt_y;
  assign colour_o    = colour_q;
  assign next_xpixel = xpix_q;
  assign next_ypixel = ypix_q;
  assign first       = first_q;
  assign last_x      = last_x_q;
  assign last_y      = last_y_q;
  assign valid       = valid_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_pixel_frame_scheduler.sv
// Self-checking bench for pixel_frame_scheduler on a 4x3 screen with a 2-cycle gap.
module tb_pixel_frame_scheduler;

  localparam int W   = 4;
  localparam int H   = 3;
  localparam int GAP = 2;
  localparam int DW  = 32;
  localparam int CW  = 24;
  localparam int NPIX = W * H;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          en;
  logic          src_req;
  logic [DW-1:0] src_x, src_y;
  logic [CW-1:0] src_colour;
  logic          src_valid;
  logic [CW-1:0] colour_o;
  logic [DW-1:0] next_xpixel, next_ypixel;
  logic          first, last_x, last_y, valid, ready, busy, frame_done;
  logic [15:0]   frame_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int lat;
    int stall;
    bit spur;
    bit drop_en;
    int x;
    int y;
    bit f;
    bit lx;
    bit ly;
  } vec_t;

  typedef struct {
    logic [CW-1:0] colour;
    int x;
    int y;
    bit f;
    bit lx;
    bit ly;
  } exp_t;

  vec_t tbl[3*NPIX];
  exp_t sb[$];

  pixel_frame_scheduler #(
    .DATA_WIDTH   (DW),
    .RBG_SIZE     (CW),
    .SCREEN_WIDTH (W),
    .SCREEN_HEIGHT(H),
    .GAP_CYCLES   (GAP)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en),
    .src_req    (src_req),
    .src_x      (src_x),
    .src_y      (src_y),
    .src_colour (src_colour),
    .src_valid  (src_valid),
    .colour_o   (colour_o),
    .next_xpixel(next_xpixel),
    .next_ypixel(next_ypixel),
    .first      (first),
    .last_x     (last_x),
    .last_y     (last_y),
    .valid      (valid),
    .ready      (ready),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pack_stream();
    return {20'h0, colour_o, next_xpixel[7:0], next_ypixel[7:0], first, last_x, last_y, valid};
  endfunction

  task automatic reset_checks(input string tag);
    chk({tag, "_ctl"}, {57'h0, valid, src_req, busy, frame_done, first, last_x, last_y}, 64'h0);
    chk({tag, "_count"}, 64'(frame_count), 64'h0);
    chk({tag, "_src_xy"}, {src_x, src_y}, 64'h0);
    chk({tag, "_pix_xy"}, {next_xpixel, next_ypixel}, 64'h0);
    chk({tag, "_colour"}, 64'(colour_o), 64'h0);
  endtask

  // Drives one pixel transaction; starts and ends just after a rising edge.
  task automatic do_pixel(input vec_t p, output int waited);
    exp_t e;
    exp_t g;
    logic [63:0] snap;
    waited = 0;
    @(negedge clk);
    while (!src_req && waited < 60) begin
      @(posedge clk); #1;
      waited++;
      @(negedge clk);
    end
    chk("req_seen", 64'(src_req), 64'h1);
    chk("req_x", 64'(src_x), 64'(p.x));
    chk("req_y", 64'(src_y), 64'(p.y));
    e.colour = CW'(p.x + 16 * p.y);
    e.x = p.x; e.y = p.y; e.f = p.f; e.lx = p.lx; e.ly = p.ly;
    sb.push_back(e);
    @(posedge clk); #1;
    chk("req_pulse", 64'(src_req), 64'h0);
    repeat (p.lat - 1) begin @(posedge clk); #1; end
    src_colour = e.colour;
    src_valid  = 1'b1;
    @(posedge clk); #1;
    src_valid  = 1'b0;
    src_colour = '0;
    ready = (p.stall == 0);
    if (p.spur) begin
      src_valid  = 1'b1;
      src_colour = 24'hBADBAD;
    end
    @(negedge clk);
    chk("valid_latency", 64'(valid), 64'h1);
    snap = pack_stream();
    for (int s = 0; s < p.stall; s++) begin
      @(posedge clk); #1;
      src_valid = 1'b0;
      if (s == p.stall - 1) ready = 1'b1;
      @(negedge clk);
      chk("stall_hold", pack_stream(), snap);
      chk("stall_noreq", 64'(src_req), 64'h0);
    end
    if (p.drop_en) en = 1'b0;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL sb_pop: got empty queue want one entry");
    end else begin
      g = sb.pop_front();
      chk("pix_colour", 64'(colour_o), 64'(g.colour));
      chk("pix_x", 64'(next_xpixel), 64'(g.x));
      chk("pix_y", 64'(next_ypixel), 64'(g.y));
      chk("pix_markers", {61'h0, first, last_x, last_y}, {61'h0, g.f, g.lx, g.ly});
    end
    @(posedge clk); #1;
    src_valid = 1'b0;
  endtask

  // Follows the last handshake of frame n through the gap.
  task automatic gap_check(input int n);
    @(negedge clk);
    chk("gap1_done", 64'(frame_done), 64'h0);
    chk("gap1_count", 64'(frame_count), 64'(n - 1));
    chk("gap1_state", {62'h0, busy, valid}, {62'h0, 1'b1, 1'b0});
    @(posedge clk); #1;
    @(negedge clk);
    chk("gap2_done", 64'(frame_done), 64'h1);
    chk("gap2_count", 64'(frame_count), 64'(n));
    @(posedge clk); #1;
    chk("done_pulse_end", 64'(frame_done), 64'h0);
  endtask

  initial begin
    int w;
    int j;
    for (int i = 0; i < 3 * NPIX; i++) begin
      j = i % NPIX;
      tbl[i].x = j % W;
      tbl[i].y = j / W;
      tbl[i].f = (j == 0);
      tbl[i].lx = ((j + 1) % W == 0);
      tbl[i].ly = (j == NPIX - 1);
      tbl[i].lat = (i >= NPIX && i < 2 * NPIX) ? 7 : 1;
      tbl[i].stall = 0;
      tbl[i].spur = 1'b0;
      tbl[i].drop_en = 1'b0;
    end
    tbl[6].stall = 5;
    tbl[12].spur = 1'b1;
    tbl[14].stall = 3;  tbl[14].spur = 1'b1;
    tbl[19].stall = 3;  tbl[19].spur = 1'b1;
    tbl[25].drop_en = 1'b1;
    tbl[30].stall = 2;

    reset_n = 1'b0; en = 1'b0; ready = 1'b0; src_valid = 1'b0; src_colour = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_checks("reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'h0);
    @(posedge clk); #1;
    en = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 3 * NPIX; i++) begin
      do_pixel(tbl[i], w);
      chk("req_latency", 64'(w), 64'h0);
      if (tbl[i].drop_en) begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("paused_idle", {62'h0, busy, src_req}, 64'h0);
          @(posedge clk); #1;
        end
        en = 1'b1;
        @(posedge clk); #1;
      end
      if (i % NPIX == NPIX - 1) gap_check(i / NPIX + 1);
    end

    for (int i = 0; i < 7; i++) begin
      do_pixel(tbl[i], w);
      chk("req_latency", 64'(w), 64'h0);
    end
    @(negedge clk);
    chk("mid_req", {src_x, src_y}, {32'd3, 32'd1});
    @(posedge clk); #1;
    chk("mid_busy", {62'h0, busy, src_req}, {62'h0, 1'b1, 1'b0});
    reset_n = 1'b0;
    #1;
    reset_checks("midrst");
    sb.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_count", 64'(frame_count), 64'h0);
    do_pixel(tbl[0], w);
    chk("req_latency", 64'(w), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
